channel_collector_64: RTL and testbench

CHANNEL_COLLECTOR_64 -- requirements
Module: channel_collector_64

---
 rtl/channel_collector_64.sv | 87 ++++++++
 tb/tb_channel_collector_64.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/channel_collector_64.sv
// rtl/channel_collector_64.sv - serial-to-parallel frame collector feeding a 64-input adder tree
module channel_collector_64 #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 64,
  localparam int IDX_W     = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_WIDTH-1:0]        Data_In,
  input  logic                         Valid_In,
  input  logic                         Last_In,
  input  logic                         Clear,
  output logic [NUM_CH*DATA_WIDTH-1:0] Data_Out,
  output logic                         Valid_Out,
  output logic [IDX_W-1:0]             Fill_Count
);

  // Partial-frame storage; never reset because stale entries beyond wr_idx
  // are replaced by zero when the output bank loads.
  logic [DATA_WIDTH-1:0]        fill_q [NUM_CH];
  logic [IDX_W-1:0]             wr_idx_q, wr_idx_d;
  logic [NUM_CH*DATA_WIDTH-1:0] bank_q, bank_d;
  logic                         valid_q;

  logic accept;
  logic complete;

  // Clear wins over Valid_In; a frame ends on the last slot or an explicit Last_In.
  assign accept   = Valid_In & ~Clear;
  assign complete = accept & ((wr_idx_q == IDX_W'(NUM_CH - 1)) | Last_In);

  // Write index: wraps to 0 on completion, forced to 0 by Clear.
  always_comb begin
    wr_idx_d = wr_idx_q;
    if (Clear) begin
      wr_idx_d = '0;
    end else if (accept) begin
      if (complete) begin
        wr_idx_d = '0;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end
  end

  // Output bank next state: on completion, stored words below wr_idx, the
  // live word at wr_idx, and +0.0 above so unused channels add nothing.
  always_comb begin
    bank_d = bank_q;
    if (complete) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (IDX_W'(k) < wr_idx_q) begin
          bank_d[k*DATA_WIDTH +: DATA_WIDTH] = fill_q[k];
        end else if (IDX_W'(k) == wr_idx_q) begin
          bank_d[k*DATA_WIDTH +: DATA_WIDTH] = Data_In;
        end else begin
          bank_d[k*DATA_WIDTH +: DATA_WIDTH] = '0;
        end
      end
    end
  end

  // Capture accepted words into the fill buffer.
  always_ff @(posedge clk) begin
    if (accept) begin
      fill_q[wr_idx_q] <= Data_In;
    end
  end

  // Index, output bank and completion pulse, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q <= '0;
      bank_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_idx_q <= wr_idx_d;
      bank_q   <= bank_d;
      valid_q  <= complete;
    end
  end

  assign Data_Out   = bank_q;
  assign Valid_Out  = valid_q;
  assign Fill_Count = wr_idx_q;

endmodule

// File: tb/tb_channel_collector_64.sv
// tb/tb_channel_collector_64.sv - self-checking bench for channel_collector_64
module tb_channel_collector_64;

  localparam int DW = 32;
  localparam int NC = 64;
  localparam int IW = 6;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [DW-1:0]  din;
  logic           vin, lin, clr;
  logic [NC*DW-1:0] dout;
  logic           vout;
  logic [IW-1:0]  fcnt;

  int checks = 0;
  int errors = 0;

  // Reference model: the partial frame as a queue, the last completed frame as an array.
  logic [DW-1:0] part[$];
  logic [DW-1:0] exp_bank[NC];
  bit            exp_valid;
  int            pulses;

  typedef struct {
    bit          v, l, c;
    logic [31:0] d;
    bit          ev;
    int          ef;
    logic [31:0] e0, e4, e5;
  } vec_t;
  vec_t tbl[12];

  channel_collector_64 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Data_In    (din),
    .Valid_In   (vin),
    .Last_In    (lin),
    .Clear      (clr),
    .Data_Out   (dout),
    .Valid_Out  (vout),
    .Fill_Count (fcnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ch(input int k);
    return dout[k*DW +: DW];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic chk_frame(input string name, input logic [DW-1:0] want[NC]);
    int bad;
    bad = -1;
    for (int k = NC - 1; k >= 0; k--) begin
      if (ch(k) !== want[k]) bad = k;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: channel %0d got %0h expected %0h", name, bad, ch(bad), want[bad]);
    end
  endtask

  task automatic model_reset();
    part.delete();
    for (int k = 0; k < NC; k++) exp_bank[k] = '0;
    exp_valid = 1'b0;
  endtask

  task automatic model_step(input bit v, input bit l, input bit c, input logic [DW-1:0] d);
    exp_valid = 1'b0;
    if (c) begin
      part.delete();
    end else if (v) begin
      part.push_back(d);
      if (part.size() == NC || l) begin
        for (int k = 0; k < NC; k++) exp_bank[k] = (k < part.size()) ? part[k] : '0;
        exp_valid = 1'b1;
        part.delete();
      end
    end
  endtask

  task automatic check_model();
    chk("valid_out", 64'(vout), 64'(exp_valid));
    chk("fill_count", 64'(fcnt), 64'(part.size()));
    chk_frame("data_out", exp_bank);
    if (vout) pulses++;
  endtask

  // One clock: drive, let the edge happen, advance the model, sample 1 ns later.
  task automatic step(input bit v, input bit l, input bit c, input logic [DW-1:0] d);
    vin = v; lin = l; clr = c; din = d;
    @(posedge clk);
    model_step(v, l, c, d);
    #1;
    check_model();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, $urandom);
  endtask

  // Mid-cycle asynchronous reset, checked before any clock edge can occur.
  task automatic do_reset();
    vin = 1'b0; lin = 1'b0; clr = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(vout), 64'd0);
    chk("rst_fill", 64'(fcnt), 64'd0);
    chk("rst_data_zero", 64'(dout == '0), 64'd1);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [DW-1:0] want[NC];
  int            pulse_at[$];

  initial begin
    rst_n = 1'b0; vin = 1'b0; lin = 1'b0; clr = 1'b0; din = '0;
    pulses = 0;
    model_reset();
    #12;
    chk("reset_valid", 64'(vout), 64'd0);
    chk("reset_fill", 64'(fcnt), 64'd0);
    chk("reset_data_zero", 64'(dout == '0), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Hand-computed vectors: short frame, ignored Last_In, Last_In at index 0, Clear.
    tbl[0]  = '{1, 0, 0, 32'h3F80_0000, 0, 1, 32'h0,         32'h0,         32'h0};
    tbl[1]  = '{1, 0, 0, 32'h3F80_0000, 0, 2, 32'h0,         32'h0,         32'h0};
    tbl[2]  = '{1, 0, 0, 32'h3F80_0000, 0, 3, 32'h0,         32'h0,         32'h0};
    tbl[3]  = '{0, 1, 0, 32'hDEAD_BEEF, 0, 3, 32'h0,         32'h0,         32'h0};
    tbl[4]  = '{1, 0, 0, 32'h3F80_0000, 0, 4, 32'h0,         32'h0,         32'h0};
    tbl[5]  = '{1, 1, 0, 32'h3F80_0000, 1, 0, 32'h3F80_0000, 32'h3F80_0000, 32'h0};
    tbl[6]  = '{0, 0, 0, 32'h0,         0, 0, 32'h3F80_0000, 32'h3F80_0000, 32'h0};
    tbl[7]  = '{1, 1, 0, 32'h1234_5678, 1, 0, 32'h1234_5678, 32'h0,         32'h0};
    tbl[8]  = '{1, 0, 0, 32'hAAAA_0001, 0, 1, 32'h1234_5678, 32'h0,         32'h0};
    tbl[9]  = '{1, 0, 1, 32'hBBBB_0001, 0, 0, 32'h1234_5678, 32'h0,         32'h0};
    tbl[10] = '{1, 1, 0, 32'hCCCC_0002, 1, 0, 32'hCCCC_0002, 32'h0,         32'h0};
    tbl[11] = '{0, 0, 1, 32'h0,         0, 0, 32'hCCCC_0002, 32'h0,         32'h0};
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].v, tbl[i].l, tbl[i].c, tbl[i].d);
      chk($sformatf("tbl%0d_valid", i), 64'(vout), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_fill", i), 64'(fcnt), 64'(tbl[i].ef));
      chk($sformatf("tbl%0d_ch0", i), 64'(ch(0)), 64'(tbl[i].e0));
      chk($sformatf("tbl%0d_ch4", i), 64'(ch(4)), 64'(tbl[i].e4));
      chk($sformatf("tbl%0d_ch5", i), 64'(ch(5)), 64'(tbl[i].e5));
    end

    // Full frame of k = 0..63.
    pulses = 0;
    for (int k = 0; k < NC; k++) step(1'b1, 1'b0, 1'b0, DW'(k));
    idle();
    for (int k = 0; k < NC; k++) want[k] = DW'(k);
    chk_frame("full_frame", want);
    chk("full_pulses", 64'(pulses), 64'd1);

    // Back-to-back frames: pulses exactly 64 cycles apart.
    pulse_at.delete();
    for (int i = 0; i < 2 * NC; i++) begin
      step(1'b1, 1'b0, 1'b0, DW'(((i / NC) + 1) * 1000 + (i % NC)));
      if (vout) pulse_at.push_back(i);
    end
    chk("b2b_pulse_count", 64'(pulse_at.size()), 64'd2);
    if (pulse_at.size() == 2) chk("b2b_spacing", 64'(pulse_at[1] - pulse_at[0]), 64'd64);
    for (int k = 0; k < NC; k++) want[k] = DW'(2000 + k);
    chk_frame("b2b_frame2", want);

    // Clear with a concurrent word at Fill_Count 10.
    pulses = 0;
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b0, DW'(500 + k));
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    chk("clear_fill", 64'(fcnt), 64'd0);
    chk("clear_pulses", 64'(pulses), 64'd0);
    for (int k = 0; k < NC; k++) step(1'b1, 1'b0, 1'b0, DW'(3000 + k));
    for (int k = 0; k < NC; k++) want[k] = DW'(3000 + k);
    chk_frame("clear_next_frame", want);
    chk("clear_next_pulses", 64'(pulses), 64'd1);

    // Reset at Fill_Count 40; next word must land in channel 0.
    pulses = 0;
    for (int k = 0; k < 40; k++) step(1'b1, 1'b0, 1'b0, DW'(700 + k));
    do_reset();
    idle();
    chk("rst_no_pulse", 64'(pulses), 64'd0);
    step(1'b1, 1'b1, 1'b0, 32'h5555_AAAA);
    chk("rst_next_ch0", 64'(ch(0)), 64'h5555_AAAA);
    chk("rst_next_ch1", 64'(ch(1)), 64'd0);

    // Gapped input: same frame as the gap-free case.
    pulses = 0;
    for (int k = 0; k < NC; k++) begin
      repeat ($urandom_range(0, 3)) idle();
      step(1'b1, 1'b0, 1'b0, DW'(k));
    end
    repeat (3) idle();
    for (int k = 0; k < NC; k++) want[k] = DW'(k);
    chk_frame("gapped_frame", want);
    chk("gapped_pulses", 64'(pulses), 64'd1);

    // Random traffic against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
             $urandom_range(0, 49) == 0, $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
